// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: answers a host start pulse with preamble, 40-bit frame, end pulse.
// Optional macro DHT11_RSP_BAD_CSUM_EN adds iCorruptCsum to flip the checksum LSB.
module dht11_responder #(
  parameter int unsigned P_START_MIN_US = 18000,
  parameter int unsigned P_WAIT_US      = 30,
  parameter int unsigned P_RESP_LOW_US  = 80,
  parameter int unsigned P_RESP_HIGH_US = 80,
  parameter int unsigned P_BIT_LOW_US   = 50,
  parameter int unsigned P_BIT0_HIGH_US = 26,
  parameter int unsigned P_BIT1_HIGH_US = 70
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iTickUs,
  input  logic       iDataIn,
  output logic       oDataOe,
  input  logic [7:0] iHumInt,
  input  logic [7:0] iHumDec,
  input  logic [7:0] iTempInt,
  input  logic [7:0] iTempDec,
`ifdef DHT11_RSP_BAD_CSUM_EN
  input  logic       iCorruptCsum,
`endif
  output logic       oBusy,
  output logic       oFrameDone,
  output logic [7:0] oStartCnt
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HOST_LOW,
    S_WAIT,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_END_LOW,
    S_RELEASE
  } state_t;

  // Limits are "last tick index" so a phase lasts exactly P ticks.
  localparam logic [14:0] L_START = 15'(P_START_MIN_US);
  localparam logic [14:0] L_WAIT  = 15'(P_WAIT_US - 1);
  localparam logic [14:0] L_RLOW  = 15'(P_RESP_LOW_US - 1);
  localparam logic [14:0] L_RHIGH = 15'(P_RESP_HIGH_US - 1);
  localparam logic [14:0] L_BLOW  = 15'(P_BIT_LOW_US - 1);
  localparam logic [14:0] L_B0    = 15'(P_BIT0_HIGH_US - 1);
  localparam logic [14:0] L_B1    = 15'(P_BIT1_HIGH_US - 1);

  state_t      state;
  state_t      state_n;
  logic [1:0]  sync;
  logic        line;
  logic [14:0] cnt;
  logic [5:0]  idx;
  logic [39:0] frame;
  logic [7:0]  start_cnt;
  logic [7:0]  csum;
  logic        corrupt;
  logic        cur_bit;
  logic        accept;
  logic        load_idx;
  logic        dec_idx;
  logic        oe;
  logic        busy;
  logic        done;

  function automatic logic hit(
    input logic        t,
    input logic [14:0] c,
    input logic [14:0] lim
  );
    return t && (c >= lim);
  endfunction

`ifdef DHT11_RSP_BAD_CSUM_EN
  assign corrupt = iCorruptCsum;
`else
  assign corrupt = 1'b0;
`endif

  assign line    = sync[1];
  assign csum    = (iHumInt + iHumDec + iTempInt + iTempDec)
                   ^ {7'd0, corrupt};
  assign cur_bit = frame[idx];

  always_comb begin
    state_n  = state;
    oe       = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    load_idx = 1'b0;
    dec_idx  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!line) state_n = S_HOST_LOW;
      end
      S_HOST_LOW: begin
        if (line) begin
          if (cnt >= L_START) begin
            accept  = 1'b1;
            state_n = S_WAIT;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (hit(iTickUs, cnt, L_WAIT)) state_n = S_RESP_LOW;
      end
      S_RESP_LOW: begin
        busy = 1'b1;
        oe   = 1'b1;
        if (hit(iTickUs, cnt, L_RLOW)) state_n = S_RESP_HIGH;
      end
      S_RESP_HIGH: begin
        busy = 1'b1;
        if (hit(iTickUs, cnt, L_RHIGH)) begin
          load_idx = 1'b1;
          state_n  = S_BIT_LOW;
        end
      end
      S_BIT_LOW: begin
        busy = 1'b1;
        oe   = 1'b1;
        if (hit(iTickUs, cnt, L_BLOW)) state_n = S_BIT_HIGH;
      end
      S_BIT_HIGH: begin
        busy = 1'b1;
        if (hit(iTickUs, cnt, cur_bit ? L_B1 : L_B0)) begin
          if (idx == 6'd0) begin
            state_n = S_END_LOW;
          end else begin
            dec_idx = 1'b1;
            state_n = S_BIT_LOW;
          end
        end
      end
      S_END_LOW: begin
        busy = 1'b1;
        oe   = 1'b1;
        if (hit(iTickUs, cnt, L_BLOW)) state_n = S_RELEASE;
      end
      S_RELEASE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state     <= S_IDLE;
      sync      <= 2'b11;
      cnt       <= '0;
      idx       <= '0;
      frame     <= '0;
      start_cnt <= '0;
    end else begin
      sync  <= {sync[0], iDataIn};
      state <= state_n;
      if (state_n != state) begin
        cnt <= '0;
      end else if (iTickUs && cnt != '1) begin
        cnt <= cnt + 15'd1;
      end
      if (accept) begin
        frame     <= {iHumInt, iHumDec, iTempInt, iTempDec, csum};
        start_cnt <= start_cnt + 8'd1;
      end
      if (load_idx) begin
        idx <= 6'd39;
      end else if (dec_idx) begin
        idx <= idx - 6'd1;
      end
    end
  end

  assign oDataOe    = oe;
  assign oBusy      = busy;
  assign oFrameDone = done;
  assign oStartCnt  = start_cnt;

endmodule
